// File: rtl/mib_slave_if.sv
// MIB configuration bus slave: decodes master transactions on the shared bus and performs
// one 32-bit local register access, returning read data over the same tri-stated bus.
module mib_slave_if #(
  parameter logic [3:0]  P_SLAVE_SEL            = 4'h0,
  parameter int unsigned P_CMD_ACK_TIMEOUT_CLKS = 32
) (
  input  logic        CLK,
  input  logic        i_arst_n,
  input  logic        i_mib_start,
  input  logic        i_mib_rd_wr_n,
  output logic        o_mib_slave_ack,
  inout  wire  [15:0] mib_dabus,
  output logic [19:0] o_reg_addr,
  output logic [31:0] o_reg_wdata,
  output logic        o_reg_wr,
  output logic        o_reg_rd,
  input  logic [31:0] i_reg_rdata,
  input  logic        i_reg_ack,
  output logic        o_timeout
);

  localparam int unsigned   CntW    = $clog2(P_CMD_ACK_TIMEOUT_CLKS) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(P_CMD_ACK_TIMEOUT_CLKS - 1);

  typedef enum logic [3:0] {
    StIdle, StAddrLo, StWdataHi, StWdataLo, StRegWait, StAck, StRdHi, StRdLo, StIgnore
  } state_e;

  state_e          state_q, state_d;
  logic            rd_q;
  logic [7:0]      addr_hi_q;
  logic [19:0]     reg_addr_q;
  logic [15:0]     wdata_hi_q;
  logic [31:0]     reg_wdata_q;
  logic [31:0]     rdata_q;
  logic [CntW-1:0] cnt_q;
  logic            ign_q;
  logic            reg_wr_q, reg_rd_q;
  logic            wr_set, rd_set;
  logic            bus_oe;
  logic [15:0]     bus_out;

  assign mib_dabus   = bus_oe ? bus_out : 16'hzzzz;
  assign o_reg_addr  = reg_addr_q;
  assign o_reg_wdata = reg_wdata_q;
  assign o_reg_wr    = reg_wr_q;
  assign o_reg_rd    = reg_rd_q;

  // Bus drive and ack decode straight from state so an async reset releases them at once.
  always_comb begin
    state_d         = state_q;
    wr_set          = 1'b0;
    rd_set          = 1'b0;
    bus_oe          = 1'b0;
    bus_out         = 16'h0000;
    o_mib_slave_ack = 1'b0;
    o_timeout       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_mib_start) state_d = StAddrLo;
      end
      StAddrLo: begin
        if (addr_hi_q[7:4] != P_SLAVE_SEL) begin
          state_d = rd_q ? StIdle : StIgnore;
        end else if (rd_q) begin
          state_d = StRegWait;
          rd_set  = 1'b1;
        end else begin
          state_d = StWdataHi;
        end
      end
      StWdataHi: state_d = StWdataLo;
      StWdataLo: begin
        state_d = StRegWait;
        wr_set  = 1'b1;
      end
      StRegWait: begin
        if (i_reg_ack) begin
          state_d = rd_q ? StRdHi : StAck;
        end else if (cnt_q == CntLast) begin
          o_timeout = 1'b1;
          state_d   = StIdle;
        end
      end
      StAck: begin
        o_mib_slave_ack = 1'b1;
        state_d         = StIdle;
      end
      StRdHi: begin
        bus_oe          = 1'b1;
        bus_out         = rdata_q[31:16];
        o_mib_slave_ack = 1'b1;
        state_d         = StRdLo;
      end
      StRdLo: begin
        bus_oe  = 1'b1;
        bus_out = rdata_q[15:0];
        state_d = StIdle;
      end
      StIgnore: begin
        if (ign_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= StIdle;
      rd_q        <= 1'b0;
      addr_hi_q   <= 8'h00;
      reg_addr_q  <= 20'h00000;
      wdata_hi_q  <= 16'h0000;
      reg_wdata_q <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      cnt_q       <= '0;
      ign_q       <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reg_wr_q <= wr_set;
      reg_rd_q <= rd_set;
      if (state_q == StIdle && i_mib_start) begin
        addr_hi_q <= mib_dabus[7:0];
        rd_q      <= i_mib_rd_wr_n;
      end
      // Non-selected traffic leaves the previous local address untouched.
      if (state_q == StAddrLo && addr_hi_q[7:4] == P_SLAVE_SEL) begin
        reg_addr_q <= {addr_hi_q[3:0], mib_dabus};
      end
      if (state_q == StWdataHi) wdata_hi_q <= mib_dabus;
      if (state_q == StWdataLo) reg_wdata_q <= {wdata_hi_q, mib_dabus};
      if (state_q == StRegWait && i_reg_ack && rd_q) rdata_q <= i_reg_rdata;
      if (state_q != StRegWait) begin
        cnt_q <= '0;
      end else if (!i_reg_ack) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      ign_q <= (state_q == StIgnore) ? ~ign_q : 1'b0;
    end
  end

endmodule

// File: tb/tb_mib_slave_if.sv
// Bench for mib_slave_if: directed and random transactions checked cycle by cycle against
// expected event times derived from the bus protocol rules.
module tb_mib_slave_if;

  localparam logic [3:0] SEL  = 4'h3;
  localparam int         T    = 32;
  localparam int         NCYC = 45;

  logic        CLK = 1'b0;
  logic        i_arst_n;
  logic        i_mib_start;
  logic        i_mib_rd_wr_n;
  logic        o_mib_slave_ack;
  wire  [15:0] mib_dabus;
  logic [19:0] o_reg_addr;
  logic [31:0] o_reg_wdata;
  logic        o_reg_wr;
  logic        o_reg_rd;
  logic [31:0] i_reg_rdata;
  logic        i_reg_ack;
  logic        o_timeout;

  logic        tb_drv;
  logic [15:0] tb_bus;
  int          checks = 0;
  int          errors = 0;

  assign mib_dabus = tb_drv ? tb_bus : 16'hzzzz;

  mib_slave_if #(
    .P_SLAVE_SEL           (SEL),
    .P_CMD_ACK_TIMEOUT_CLKS(T)
  ) dut (
    .CLK            (CLK),
    .i_arst_n       (i_arst_n),
    .i_mib_start    (i_mib_start),
    .i_mib_rd_wr_n  (i_mib_rd_wr_n),
    .o_mib_slave_ack(o_mib_slave_ack),
    .mib_dabus      (mib_dabus),
    .o_reg_addr     (o_reg_addr),
    .o_reg_wdata    (o_reg_wdata),
    .o_reg_wr       (o_reg_wr),
    .o_reg_rd       (o_reg_rd),
    .i_reg_rdata    (i_reg_rdata),
    .i_reg_ack      (i_reg_ack),
    .o_timeout      (o_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " ack"}, {31'd0, o_mib_slave_ack}, 32'd0);
    chk({tag, " wr"}, {31'd0, o_reg_wr}, 32'd0);
    chk({tag, " rd"}, {31'd0, o_reg_rd}, 32'd0);
    chk({tag, " timeout"}, {31'd0, o_timeout}, 32'd0);
    chk({tag, " bus"}, {16'd0, mib_dabus}, {16'd0, 16'hzzzz});
  endtask

  // One master transaction starting at cycle 0. d: local ack delay after the strobe cycle
  // (outside 0..T-1 means never); late/restart/rst_at: cycle numbers, -1 for none.
  task automatic run_txn(input bit rd, input logic [23:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdv, input int d, input int late,
                         input int restart, input int rst_at);
    logic [15:0] words [4];
    logic [15:0] exp_bus;
    logic [7:0]  junk;
    bit          sel;
    int          s, a, nw;
    sel      = (addr[23:20] == SEL);
    s        = rd ? 2 : 4;
    a        = (sel && d >= 0 && d < T) ? s + d : -1;
    nw       = rd ? 2 : 4;
    junk     = 8'($urandom);
    words[0] = {junk, addr[23:16]};
    words[1] = addr[15:0];
    words[2] = wd[31:16];
    words[3] = wd[15:0];
    for (int k = 0; k < NCYC; k++) begin
      i_mib_start   = (k == 0) || (k == restart);
      i_mib_rd_wr_n = (k == 0) ? rd : 1'($urandom);
      tb_drv        = (k < nw);
      tb_bus        = (k < nw) ? words[k] : 16'h0000;
      i_reg_ack     = (k == a) || (k == late);
      i_reg_rdata   = (k == a) ? rdv : $urandom;
      @(negedge CLK);
      if (k < nw)                          exp_bus = words[k];
      else if (sel && rd && a >= 0 && k == a + 1) exp_bus = rdv[31:16];
      else if (sel && rd && a >= 0 && k == a + 2) exp_bus = rdv[15:0];
      else                                 exp_bus = 16'hzzzz;
      chk($sformatf("wr@%0d", k), {31'd0, o_reg_wr}, {31'd0, sel && !rd && k == s});
      chk($sformatf("rd@%0d", k), {31'd0, o_reg_rd}, {31'd0, sel && rd && k == s});
      chk($sformatf("timeout@%0d", k), {31'd0, o_timeout}, {31'd0, sel && a < 0 && k == s + T - 1});
      chk($sformatf("ack@%0d", k), {31'd0, o_mib_slave_ack}, {31'd0, a >= 0 && k == a + 1});
      chk($sformatf("bus@%0d", k), {16'd0, mib_dabus}, {16'd0, exp_bus});
      if (sel && k >= s) chk($sformatf("addr@%0d", k), {12'd0, o_reg_addr}, {12'd0, addr[19:0]});
      if (sel && !rd && k >= s) chk($sformatf("wdata@%0d", k), o_reg_wdata, wd);
      if (k == rst_at) begin
        i_arst_n    = 1'b0;
        i_mib_start = 1'b0;
        i_reg_ack   = 1'b0;
        tb_drv      = 1'b0;
        #1;
        chk_idle_outputs($sformatf("async_rst@%0d", k));
        @(posedge CLK);
        #1;
        chk("rst addr", {12'd0, o_reg_addr}, 32'd0);
        chk("rst wdata", o_reg_wdata, 32'd0);
        i_arst_n = 1'b1;
        return;
      end
      @(posedge CLK);
      #1;
    end
    i_mib_start = 1'b0;
    i_reg_ack   = 1'b0;
    tb_drv      = 1'b0;
  endtask

  initial begin
    bit          rd;
    logic [23:0] addr;
    int          d, restart;
    i_arst_n      = 1'b0;
    i_mib_start   = 1'b0;
    i_mib_rd_wr_n = 1'b0;
    i_reg_rdata   = 32'h0;
    i_reg_ack     = 1'b0;
    tb_drv        = 1'b0;
    tb_bus        = 16'h0;
    #3;
    chk_idle_outputs("reset");
    chk("reset addr", {12'd0, o_reg_addr}, 32'd0);
    chk("reset wdata", o_reg_wdata, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    i_arst_n = 1'b1;
    @(posedge CLK);
    #1;

    // Selected write, local ack two cycles after the strobe.
    run_txn(1'b0, 24'h31_0040, 32'hDEAD_BEEF, 32'h0, 2, -1, -1, -1);
    // Selected read with immediate local ack.
    run_txn(1'b1, 24'h30_0008, 32'h0, 32'h1234_5678, 0, -1, -1, -1);
    // Non-selected write and read, with a stray local ack while idle.
    run_txn(1'b0, 24'h52_1111, 32'hCAFE_F00D, 32'h0, 0, 4, -1, -1);
    run_txn(1'b1, 24'h5F_2222, 32'h0, 32'hAAAA_5555, 0, 2, -1, -1);
    run_txn(1'b0, 24'h3F_FFFF, 32'h0123_4567, 32'h0, 0, -1, -1, -1);
    // Read timeout followed by a late local ack.
    run_txn(1'b1, 24'h30_0100, 32'h0, 32'h9999_0000, -1, 40, -1, -1);
    // Boundary: ack on the last cycle before timeout.
    run_txn(1'b1, 24'h3A_BCDE, 32'h0, 32'h8765_4321, T - 1, -1, -1, -1);
    // Second start during WDATA_HI must be ignored.
    run_txn(1'b0, 24'h31_2345, 32'h1357_9BDF, 32'h0, 1, -1, 2, -1);
    // Reset during RD_HI, then a fresh write.
    run_txn(1'b1, 24'h30_0004, 32'h0, 32'hFEDC_BA98, 0, -1, -1, 3);
    run_txn(1'b0, 24'h30_0ABC, 32'h0F0F_F0F0, 32'h0, 0, -1, -1, -1);

    for (int n = 0; n < 24; n++) begin
      rd   = 1'($urandom);
      addr = 24'($urandom);
      if ($urandom_range(0, 3) != 0) addr[23:20] = SEL;
      else if (addr[23:20] == SEL) addr[23:20] = 4'h5;
      d       = ($urandom_range(0, 4) == 0) ? T + 1 : int'($urandom_range(0, 6));
      restart = ($urandom_range(0, 1) == 1) ? (rd ? 1 : int'($urandom_range(1, 3))) : -1;
      run_txn(rd, addr, $urandom, $urandom, d, -1, restart, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mib_slave_if.md
# mib_slave_if

Board-side responder for the shared MIB configuration bus driven by the cscfg master. Every compute FPGA (cs00…cs22) instantiates one: it decodes master transactions on `mib_dabus`, performs a 32-bit local register read or write, and answers with `o_mib_slave_ack`. Read data goes back over the same tri-stated 16-bit bus. Non-selected slaves never drive the bus or ack.

## Interface
- `P_SLAVE_SEL`, 4'h0: slave select; matched against transaction address bits [23:20].
- `P_CMD_ACK_TIMEOUT_CLKS`, 32: maximum cycles to wait for `i_reg_ack`. Must be smaller than the master's MIB ack timeout.
- `CLK` in 1: sole clock.
- `i_arst_n` in 1: reset, asynchronous, active-low.
- `i_mib_start` in 1: master start strobe, one cycle, coincident with address high word.
- `i_mib_rd_wr_n` in 1: 1 = read, 0 = write; sampled with `i_mib_start`.
- `o_mib_slave_ack` out 1: one-cycle acknowledge.
- `mib_dabus` inout 16: shared address/data bus; driven only during read return.
- `o_reg_addr` out 20: local register address (addr[19:0]).
- `o_reg_wdata` out 32: local write data.
- `o_reg_wr` out 1: one-cycle local write strobe.
- `o_reg_rd` out 1: one-cycle local read strobe.
- `i_reg_rdata` in 32: local read data, valid with `i_reg_ack`.
- `i_reg_ack` in 1: local access complete.
- `o_timeout` out 1: one-cycle pulse when the local ack times out.

## Operation
- Bus word order: addr_hi (bits [7:0] = addr[23:16], [15:8] ignored), then addr_lo, then for writes data_hi, data_lo. One word per cycle, back to back.
- States:
  - IDLE: on `i_mib_start`, latch addr_hi and rd_wr_n → ADDR_LO.
  - ADDR_LO: latch addr_lo. If addr[23:20] ≠ `P_SLAVE_SEL` → IGNORE. Else write → WDATA_HI; read → REG_WAIT, pulsing `o_reg_rd`.
  - WDATA_HI: latch data[31:16] → WDATA_LO.
  - WDATA_LO: latch data[15:0] → REG_WAIT, pulsing `o_reg_wr`.
  - REG_WAIT: `i_reg_ack` is sampled from the first cycle.
    - Write ack → ACK.
    - Read ack → latch `i_reg_rdata` → RD_HI.
    - Timeout → IDLE.
  - ACK: `o_mib_slave_ack` = 1 → IDLE.
  - RD_HI: drive rdata[31:16], `o_mib_slave_ack` = 1 → RD_LO.
  - RD_LO: drive rdata[15:0], ack = 0 → IDLE. The bus is released on the following cycle.
  - IGNORE: non-selected write; skip the 2 data words, then → IDLE. Non-selected read → IDLE immediately.
- Timeout: counter cleared on REG_WAIT entry and incremented each REG_WAIT cycle without ack. At count = `P_CMD_ACK_TIMEOUT_CLKS`−1 with no ack: pulse `o_timeout`, no MIB ack, no bus drive, → IDLE. A late `i_reg_ack` in IDLE is ignored.
- `i_mib_start` in any state other than IDLE is ignored; there is no re-arm mid-transaction.
- `o_reg_addr` and `o_reg_wdata` hold from strobe until the next transaction latches new values.

## Timing
- Reset values: state IDLE; `o_mib_slave_ack`, `o_reg_wr`, `o_reg_rd`, `o_timeout` = 0; `o_reg_addr`, `o_reg_wdata` = 0; `mib_dabus` = high-Z.
- Assertion of `i_arst_n` mid-transaction releases the bus and drops ack/strobes immediately (asynchronously). No partial local write is issued.
- Write, start at cycle 0:
  - `o_reg_wr` at cycle 4.
  - With `i_reg_ack` at cycle 4, ack at cycle 5.
  - Generally, ack is one cycle after `i_reg_ack`.
- Read, start at cycle 0:
  - `o_reg_rd` at cycle 2.
  - With `i_reg_ack` at cycle 2, rdata_hi + ack at cycle 3, rdata_lo at cycle 4, high-Z at cycle 5.
- Master must release the bus by cycle 2 of a read. The slave never drives before RD_HI.
- Only one of `o_reg_wr` / `o_reg_rd` is high in any cycle. Each strobe is exactly one cycle.
- Timeout: `o_timeout` pulses `P_CMD_ACK_TIMEOUT_CLKS` cycles after the strobe cycle, counting the strobe cycle as 1.

## Test plan
- Selected write:
  - Stimulus: `P_SLAVE_SEL`=4'h3; words 0x0031, 0x0040, 0xDEAD, 0xBEEF; `i_reg_ack` at cycle 6.
  - Response: `o_reg_wr` at cycle 4 with addr 0x10040, wdata 0xDEADBEEF; ack only at cycle 7; bus never driven.
- Selected read:
  - Stimulus: words 0x0030, 0x0008; `i_reg_rdata`=0x12345678 with ack at cycle 2.
  - Response: `o_reg_rd` at cycle 2; bus = 0x1234 with ack at cycle 3; 0x5678 at cycle 4; high-Z at cycle 5.
- Non-selected:
  - Stimulus: write and read with addr[23:20]=4'h5 against `P_SLAVE_SEL`=3.
  - Response: no strobes, no ack, bus high-Z throughout. The next selected transaction completes normally.
- Timeout:
  - Stimulus: read with no `i_reg_ack`, `P_CMD_ACK_TIMEOUT_CLKS`=32; then a late ack at cycle 40.
  - Response: `o_timeout` at cycle 33, no ack, no bus drive; the late ack is ignored.
- Restart/collision:
  - Stimulus: second `i_mib_start` during WDATA_HI.
  - Response: ignored; the first write completes with the original data.
- Reset mid-read:
  - Stimulus: `i_arst_n` low during RD_HI.
  - Response: bus high-Z and ack 0 in the same timestep; after release, state is IDLE and a fresh write completes.
